// File: rtl/mf8_uart.sv
// mf8_uart: IO-mapped 8N1 UART with TX FIFO, single-byte RX holding register and level interrupt
// Ports:
//   Clk, Reset            system clock, synchronous active-high reset
//   IO_Addr/IO_Rd/IO_Wr   core IO bus strobes (one access per cycle)
//   IO_WData / IO_RData   write data in, combinational read data out (8'h00 when not selected)
//   Sel                   IO_Addr hits DATA, STATUS or CTRL
//   Rxd / Txd             serial in (asynchronous) / serial out (idle high)
//   Irq                   registered level interrupt
// Registers: DATA @BASE_ADDR, STATUS @+1 = {2'b0, tx_drop, frame_err, rx_overrun, rx_valid, tx_idle, tx_full},
//            CTRL @+2 = {6'b0, tx_ien, rx_ien}
module mf8_uart #(
  parameter logic [5:0] BASE_ADDR = 6'h0C,
  parameter int CLK_DIV = 434,
  parameter int TX_DEPTH = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [5:0] IO_Addr,
  input  logic       IO_Rd,
  input  logic       IO_Wr,
  input  logic [7:0] IO_WData,
  output logic [7:0] IO_RData,
  output logic       Sel,
  input  logic       Rxd,
  output logic       Txd,
  output logic       Irq
);
  localparam int BW = $clog2(CLK_DIV);
  localparam int AW = $clog2(TX_DEPTH);
  localparam logic [BW-1:0] BIT_END = BW'(CLK_DIV - 1);
  localparam logic [BW-1:0] HALF_END = BW'(CLK_DIV / 2 - 1);
  localparam logic [BW-1:0] C1 = BW'(1);
  localparam logic [AW:0] P1 = (AW + 1)'(1);
  localparam logic [AW:0] FULL_XOR = {1'b1, {AW{1'b0}}};
  localparam logic [5:0] STAT_ADDR = BASE_ADDR + 6'd1;
  localparam logic [5:0] CTRL_ADDR = BASE_ADDR + 6'd2;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  logic sel_data, sel_stat, sel_ctrl, wr_data, wr_stat, wr_ctrl;
  logic [7:0] fifo [TX_DEPTH];
  logic [AW:0] wp, rp;
  logic empty, full, pop, push;
  state_t tx_st, rx_st;
  logic [BW-1:0] tx_cnt, rx_cnt;
  logic [2:0] tx_bit, rx_bit;
  logic [7:0] tx_sh, rx_sh, rx_buf, status;
  logic rs1, rs2, rx_prev;
  logic rx_valid, rx_overrun, frame_err, tx_drop, rx_ien, tx_ien;
  logic tx_idle, tx_end, rx_tick, rx_stop, rx_ok, rx_bad, rd_clr;
  logic [5:3] w1c;
  assign sel_data = IO_Addr == BASE_ADDR;
  assign sel_stat = IO_Addr == STAT_ADDR;
  assign sel_ctrl = IO_Addr == CTRL_ADDR;
  assign Sel = sel_data | sel_stat | sel_ctrl;
  assign wr_data = IO_Wr & sel_data;
  assign wr_stat = IO_Wr & sel_stat;
  assign wr_ctrl = IO_Wr & sel_ctrl;
  assign w1c = {3{wr_stat}} & IO_WData[5:3];
  assign empty = wp == rp;
  assign full = (wp ^ rp) == FULL_XOR;
  assign tx_end = tx_cnt == BIT_END;
  // The FIFO is drained either by an idle transmitter or at the end of a stop bit for back-to-back frames.
  assign pop = !empty && (tx_st == IDLE || (tx_st == STOP && tx_end));
  // A simultaneous pop frees a slot, so a write to a full FIFO still lands.
  assign push = wr_data && (!full || pop);
  assign tx_idle = empty && tx_st == IDLE;
  assign rx_tick = rx_st == START ? rx_cnt == HALF_END : rx_st != IDLE && rx_cnt == BIT_END;
  assign rx_stop = rx_st == STOP && rx_cnt == BIT_END;
  assign rx_ok = rx_stop && rs2;
  assign rx_bad = rx_stop && !rs2;
  assign rd_clr = IO_Rd && sel_data && rx_valid;
  assign status = {2'b0, tx_drop, frame_err, rx_overrun, rx_valid, tx_idle, full};
  assign IO_RData = sel_data ? rx_buf : sel_stat ? status : sel_ctrl ? {6'b0, tx_ien, rx_ien} : 8'h00;
  always_ff @(posedge Clk)
    if (push) fifo[wp[AW-1:0]] <= IO_WData;
  always_ff @(posedge Clk) begin
    if (Reset) begin
      wp <= '0;
      rp <= '0;
      tx_st <= IDLE;
      tx_cnt <= '0;
      tx_bit <= '0;
      tx_sh <= '0;
      Txd <= 1'b1;
    end else begin
      if (push) wp <= wp + P1;
      if (pop) rp <= rp + P1;
      tx_cnt <= (tx_st == IDLE || tx_end) ? '0 : tx_cnt + C1;
      case (tx_st)
        IDLE: if (pop) begin
          tx_st <= START;
          tx_sh <= fifo[rp[AW-1:0]];
          Txd <= 1'b0;
        end
        START: if (tx_end) begin
          tx_st <= DATA;
          tx_bit <= '0;
          Txd <= tx_sh[0];
          tx_sh <= tx_sh >> 1;
        end
        DATA: if (tx_end) begin
          tx_bit <= tx_bit + 3'd1;
          tx_st <= tx_bit == 3'd7 ? STOP : DATA;
          Txd <= tx_bit == 3'd7 ? 1'b1 : tx_sh[0];
          tx_sh <= tx_sh >> 1;
        end
        STOP: if (tx_end) begin
          tx_st <= pop ? START : IDLE;
          tx_sh <= fifo[rp[AW-1:0]];
          Txd <= !pop;
        end
      endcase
    end
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rs1 <= 1'b1;
      rs2 <= 1'b1;
      rx_prev <= 1'b1;
      rx_st <= IDLE;
      rx_cnt <= '0;
      rx_bit <= '0;
      rx_sh <= '0;
      rx_buf <= '0;
    end else begin
      rs1 <= Rxd;
      rs2 <= rs1;
      rx_prev <= rs2;
      rx_cnt <= (rx_st == IDLE || rx_tick) ? '0 : rx_cnt + C1;
      case (rx_st)
        IDLE: if (rx_prev && !rs2) rx_st <= START;
        // Mid-start re-sample: a line already back high was a glitch.
        START: if (rx_tick) begin
          rx_st <= rs2 ? IDLE : DATA;
          rx_bit <= '0;
        end
        DATA: if (rx_tick) begin
          rx_sh <= {rs2, rx_sh[7:1]};
          rx_bit <= rx_bit + 3'd1;
          rx_st <= rx_bit == 3'd7 ? STOP : DATA;
        end
        STOP: if (rx_tick) begin
          rx_st <= IDLE;
          if (rs2) rx_buf <= rx_sh;
        end
      endcase
    end
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      {rx_valid, rx_overrun, frame_err, tx_drop, rx_ien, tx_ien, Irq} <= 7'b0;
    end else begin
      // Hardware sets take priority over both the read-clear and the write-1-to-clear.
      rx_valid <= rx_ok | (rx_valid & !rd_clr);
      rx_overrun <= (rx_ok & rx_valid & !rd_clr) | (rx_overrun & !w1c[3]);
      frame_err <= rx_bad | (frame_err & !w1c[4]);
      tx_drop <= (wr_data & full & !pop) | (tx_drop & !w1c[5]);
      if (wr_ctrl) {tx_ien, rx_ien} <= IO_WData[1:0];
      Irq <= (rx_valid & rx_ien) | (tx_idle & tx_ien);
    end
  end
endmodule
